// File: rtl/notas_turma_pkg.sv
// Shared types and helpers for the class grade collector.
package notas_pkg;

    // 7-segment letter patterns (bit 7 is the decimal point, always off)
    localparam logic [7:0] LETRA_A       = 8'b01110111;
    localparam logic [7:0] LETRA_P       = 8'b01110011;
    localparam logic [7:0] LETRA_F       = 8'b01110001;
    localparam logic [7:0] LETRA_APAGADO = 8'h00;

    typedef enum logic {
        COLETA,
        RESULTADO
    } estado_t;

    typedef enum logic [1:0] {
        CLASSE_P = 2'd0,
        CLASSE_F = 2'd1,
        CLASSE_A = 2'd2
    } classe_t;

    function automatic classe_t classifica(input int unsigned nota,
                                           input int unsigned limiar_a,
                                           input int unsigned limiar_f);
        if (nota >= limiar_a) begin
            return CLASSE_A;
        end
        if (nota >= limiar_f) begin
            return CLASSE_F;
        end
        return CLASSE_P;
    endfunction

    function automatic logic [7:0] letra(input classe_t classe);
        case (classe)
            CLASSE_A: return LETRA_A;
            CLASSE_F: return LETRA_F;
            CLASSE_P: return LETRA_P;
            default:  return LETRA_APAGADO;
        endcase
    endfunction

endpackage

// File: rtl/notas_turma_if.sv
// Grade handshake and result bus between switch logic and the collector.
interface notas_turma_if #(
    parameter int unsigned NBITS_NOTA = 4,
    parameter int unsigned N_ALUNOS   = 8
);
    localparam int unsigned CW = $clog2(N_ALUNOS + 1);

    logic [NBITS_NOTA-1:0] nota;
    logic                  nota_valid;
    logic                  nota_ready;
    logic                  limpar;
    logic [7:0]            seg;
    logic [CW-1:0]         cnt_a;
    logic [CW-1:0]         cnt_f;
    logic [CW-1:0]         cnt_p;
    logic [CW-1:0]         recebidas;
    logic [NBITS_NOTA-1:0] media;
    logic                  done;
    logic                  erro;

    modport master (
        output nota, nota_valid, limpar,
        input  nota_ready, seg, cnt_a, cnt_f, cnt_p, recebidas, media, done, erro
    );

    modport slave (
        input  nota, nota_valid, limpar,
        output nota_ready, seg, cnt_a, cnt_f, cnt_p, recebidas, media, done, erro
    );

endinterface

// File: rtl/notas_turma_classifica.sv
// Combinational grade classifier: class code plus its 7-segment letter.
module notas_classifica
    import notas_pkg::*;
#(
    parameter int unsigned NBITS_NOTA = 4,
    parameter int unsigned LIMIAR_A   = 7,
    parameter int unsigned LIMIAR_F   = 4
) (
    input  logic [NBITS_NOTA-1:0] nota,
    output classe_t               classe,
    output logic [7:0]            seg
);

    // Threshold compare and letter lookup
    always_comb begin
        classe = classifica(32'(nota), LIMIAR_A, LIMIAR_F);
        seg    = letra(classe);
    end

endmodule

// File: rtl/notas_turma.sv
// Collects one class of grades, shows each grade's letter, then the class average letter.
module notas_turma
    import notas_pkg::*;
#(
    parameter int unsigned NBITS_NOTA = 4,
    parameter int unsigned N_ALUNOS   = 8,
    parameter int unsigned NOTA_MAX   = 10,
    parameter int unsigned LIMIAR_A   = 7,
    parameter int unsigned LIMIAR_F   = 4
) (
    input  logic          clk_2,
    input  logic          rst_n,
    notas_turma_if.slave  bus
);

    localparam int unsigned CW    = $clog2(N_ALUNOS + 1);
    localparam int unsigned LOG2N = $clog2(N_ALUNOS);
    localparam int unsigned SW    = NBITS_NOTA + LOG2N;

    estado_t               estado_q, estado_d;
    logic [SW-1:0]         soma_q, soma_d;
    logic [CW-1:0]         cnt_a_q, cnt_a_d, cnt_f_q, cnt_f_d, cnt_p_q, cnt_p_d;
    logic [CW-1:0]         receb_q, receb_d;
    logic [NBITS_NOTA-1:0] media_q, media_d;
    logic [7:0]            seg_q, seg_d;
    logic                  done_q, done_d;
    logic                  erro_q, erro_d;

    logic                  aceita, legal, ultima;
    logic [SW-1:0]         soma_total;
    logic [NBITS_NOTA-1:0] media_calc;
    classe_t               classe_nota, classe_media_unused;
    logic [7:0]            seg_nota, seg_media;

    assign bus.nota_ready = (estado_q == COLETA) && !bus.limpar;
    assign aceita         = bus.nota_valid && bus.nota_ready;
    assign legal          = 32'(bus.nota) <= NOTA_MAX;
    assign ultima         = aceita && legal && (receb_q == CW'(N_ALUNOS - 1));
    assign soma_total     = soma_q + SW'(bus.nota);
    assign media_calc     = NBITS_NOTA'(soma_total >> LOG2N);

    // The average is classified from the sum including the final grade,
    // so the result letter appears on the same edge that completes the class.
    notas_classifica #(.NBITS_NOTA(NBITS_NOTA), .LIMIAR_A(LIMIAR_A), .LIMIAR_F(LIMIAR_F))
        u_class_nota (.nota(bus.nota), .classe(classe_nota), .seg(seg_nota));

    notas_classifica #(.NBITS_NOTA(NBITS_NOTA), .LIMIAR_A(LIMIAR_A), .LIMIAR_F(LIMIAR_F))
        u_class_media (.nota(media_calc), .classe(classe_media_unused), .seg(seg_media));

    // State and datapath registers
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= COLETA;
            soma_q   <= '0;
            cnt_a_q  <= '0;
            cnt_f_q  <= '0;
            cnt_p_q  <= '0;
            receb_q  <= '0;
            media_q  <= '0;
            seg_q    <= LETRA_APAGADO;
            done_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            soma_q   <= soma_d;
            cnt_a_q  <= cnt_a_d;
            cnt_f_q  <= cnt_f_d;
            cnt_p_q  <= cnt_p_d;
            receb_q  <= receb_d;
            media_q  <= media_d;
            seg_q    <= seg_d;
            done_q   <= done_d;
            erro_q   <= erro_d;
        end
    end

    // Next state: restart on limpar, move to result when the class completes
    always_comb begin
        estado_d = estado_q;
        if (bus.limpar) begin
            estado_d = COLETA;
        end else if (ultima) begin
            estado_d = RESULTADO;
        end
    end

    // Next datapath values; erro defaults low so it only pulses for one cycle
    always_comb begin
        soma_d  = soma_q;
        cnt_a_d = cnt_a_q;
        cnt_f_d = cnt_f_q;
        cnt_p_d = cnt_p_q;
        receb_d = receb_q;
        media_d = media_q;
        seg_d   = seg_q;
        done_d  = done_q;
        erro_d  = 1'b0;
        if (bus.limpar) begin
            soma_d  = '0;
            cnt_a_d = '0;
            cnt_f_d = '0;
            cnt_p_d = '0;
            receb_d = '0;
            media_d = '0;
            seg_d   = LETRA_APAGADO;
            done_d  = 1'b0;
        end else if (aceita) begin
            if (!legal) begin
                erro_d = 1'b1;
            end else begin
                soma_d  = soma_total;
                receb_d = receb_q + CW'(1);
                case (classe_nota)
                    CLASSE_A: cnt_a_d = cnt_a_q + CW'(1);
                    CLASSE_F: cnt_f_d = cnt_f_q + CW'(1);
                    default:  cnt_p_d = cnt_p_q + CW'(1);
                endcase
                if (ultima) begin
                    media_d = media_calc;
                    seg_d   = seg_media;
                    done_d  = 1'b1;
                end else begin
                    seg_d   = seg_nota;
                end
            end
        end
    end

    assign bus.seg       = seg_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_f     = cnt_f_q;
    assign bus.cnt_p     = cnt_p_q;
    assign bus.recebidas = receb_q;
    assign bus.media     = media_q;
    assign bus.done      = done_q;
    assign bus.erro      = erro_q;

endmodule

// File: tb/tb_notas_turma.sv
// Directed bench for notas_turma with a 4-grade class and a seg scoreboard.
module tb_notas_turma;

    localparam int N        = 4;
    localparam int NOTA_MAX = 10;

    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;

    notas_turma_if #(.NBITS_NOTA(4), .N_ALUNOS(N)) bus ();

    notas_turma #(.NBITS_NOTA(4), .N_ALUNOS(N), .NOTA_MAX(NOTA_MAX), .LIMIAR_A(7), .LIMIAR_F(4))
        dut (.clk_2(clk_2), .rst_n(rst_n), .bus(bus));

    always #5 clk_2 = ~clk_2;

    int errors = 0;
    int checks = 0;

    int m_a, m_f, m_p, m_rec, m_soma, m_media;
    logic [7:0] m_seg;
    logic       m_done;
    logic [7:0] sb_seg[$];

    function automatic logic [7:0] letra_ref(input int n);
        if (n >= 7) return 8'h77;
        if (n >= 4) return 8'h71;
        return 8'h73;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_a = 0; m_f = 0; m_p = 0; m_rec = 0; m_soma = 0; m_media = 0;
        m_seg = 8'h00; m_done = 1'b0;
        sb_seg.delete();
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cnt_a"}, 32'(bus.cnt_a), 32'(m_a));
        check({tag, ".cnt_f"}, 32'(bus.cnt_f), 32'(m_f));
        check({tag, ".cnt_p"}, 32'(bus.cnt_p), 32'(m_p));
        check({tag, ".recebidas"}, 32'(bus.recebidas), 32'(m_rec));
        check({tag, ".media"}, 32'(bus.media), 32'(m_media));
        check({tag, ".done"}, 32'(bus.done), 32'(m_done));
        check({tag, ".seg"}, 32'(bus.seg), 32'(m_seg));
    endtask

    // Offer one grade for one cycle; model predicts, DUT result popped after the edge.
    task automatic envia(input int n);
        logic expect_erro;
        bus.nota       = 4'(n);
        bus.nota_valid = 1'b1;
        if (n > NOTA_MAX) begin
            expect_erro = 1'b1;
        end else begin
            expect_erro = 1'b0;
            m_soma += n;
            m_rec++;
            if (n >= 7) m_a++;
            else if (n >= 4) m_f++;
            else m_p++;
            if (m_rec == N) begin
                m_media = m_soma / N;
                m_done  = 1'b1;
                m_seg   = letra_ref(m_media);
            end else begin
                m_seg = letra_ref(n);
            end
        end
        sb_seg.push_back(m_seg);
        @(posedge clk_2);
        #1;
        bus.nota_valid = 1'b0;
        if (sb_seg.size() == 0) begin
            check("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            check($sformatf("seg_after_%0d", n), 32'(bus.seg), 32'(sb_seg.pop_front()));
        end
        check($sformatf("erro_after_%0d", n), 32'(bus.erro), 32'(expect_erro));
        check($sformatf("recebidas_after_%0d", n), 32'(bus.recebidas), 32'(m_rec));
    endtask

    task automatic limpa();
        bus.limpar = 1'b1;
        #1;
        check("ready_during_limpar", 32'(bus.nota_ready), 32'(0));
        @(posedge clk_2);
        #1;
        bus.limpar = 1'b0;
        model_clear();
        #1;
        check_model("after_limpar");
        check("ready_after_limpar", 32'(bus.nota_ready), 32'(1));
    endtask

    initial begin
        bus.nota       = '0;
        bus.nota_valid = 1'b0;
        bus.limpar     = 1'b0;
        model_clear();

        // Reset state
        #12 rst_n = 1'b1;
        @(posedge clk_2);
        #1;
        check_model("reset");
        check("reset.ready", 32'(bus.nota_ready), 32'(1));
        check("reset.erro", 32'(bus.erro), 32'(0));

        // Class 8,5,2,9: letters A,F,P then average 6 -> F
        envia(8);
        envia(5);
        envia(2);
        envia(9);
        check_model("class1");
        check("class1.media_const", 32'(bus.media), 32'(6));
        check("class1.seg_const", 32'(bus.seg), 32'h71);

        // RESULTADO ignores offered grades
        bus.nota       = 4'd3;
        bus.nota_valid = 1'b1;
        #1;
        check("resultado.ready", 32'(bus.nota_ready), 32'(0));
        @(posedge clk_2);
        #1;
        bus.nota_valid = 1'b0;
        check_model("resultado_hold");
        limpa();

        // Threshold boundaries and truncating average: 10,4,6,3 -> 23/4 = 5 -> F
        envia(10);
        envia(4);
        envia(6);
        envia(3);
        check_model("class2");
        check("class2.media_const", 32'(bus.media), 32'(5));
        limpa();

        // Illegal grade pulses erro for one cycle, then a legal 7 counts as A
        envia(11);
        check_model("after_illegal");
        envia(7);
        check_model("after_7");
        check("after_7.cnt_a_const", 32'(bus.cnt_a), 32'(1));

        // limpar beats a simultaneous valid grade
        bus.nota       = 4'd9;
        bus.nota_valid = 1'b1;
        limpa();
        bus.nota_valid = 1'b0;
        @(posedge clk_2);
        #1;
        check("limpar_wins.recebidas", 32'(bus.recebidas), 32'(0));

        // Asynchronous reset mid-collection, checked between clock edges
        envia(3);
        envia(10);
        check_model("before_async_reset");
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check_model("async_reset");
        check("async_reset.erro", 32'(bus.erro), 32'(0));
        #1 rst_n = 1'b1;
        @(posedge clk_2);
        #1;
        check("post_reset.ready", 32'(bus.nota_ready), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
